// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin packet arbiter from N_REQ byte streams (in_data/in_valid/in_last -> in_ready) onto one tx_data/tx_valid/tx_ready register, with grant_id/busy status and a timeout_err pulse when a stalled lock is aborted
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int GRANT_W = 2,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [8*N_REQ-1:0]   in_data,
  input  logic [N_REQ-1:0]     in_valid,
  input  logic [N_REQ-1:0]     in_last,
  output logic [N_REQ-1:0]     in_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic [GRANT_W-1:0]   grant_id,
  output logic                 busy,
  output logic                 timeout_err
);
  typedef enum logic {ARB, LOCK} state_t;
  localparam logic [16:0] LIM = 17'(TIMEOUT_CYCLES - 1);
  state_t state_q, state_d;
  logic [GRANT_W-1:0] grant_q, grant_d, ptr_q, ptr_d, sel;
  logic [7:0] tx_data_q, tx_data_d;
  logic tx_valid_q, tx_valid_d, terr_q, terr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [N_REQ-1:0] rot, v_sh, l_sh;
  logic [2*N_REQ-1:0] dbl;
  logic acc, free;
  int off, pick;
  always_comb begin
    dbl = {in_valid, in_valid};
    rot = N_REQ'(dbl >> (int'(ptr_q) + 1));
    off = 0;
    for (int j = N_REQ - 1; j >= 0; j--) if (rot[j]) off = j;
    pick = int'(ptr_q) + 1 + off;
    pick = pick >= N_REQ ? pick - N_REQ : pick;
    sel = GRANT_W'(pick);
  end
  assign v_sh = in_valid >> grant_q;
  assign l_sh = in_last >> grant_q;
  assign free = !tx_valid_q || tx_ready;
  assign acc = state_q == LOCK && free && v_sh[0];
  assign in_ready = (state_q == LOCK && free) ? N_REQ'(1) << grant_q : '0;
  assign tx_data_d = acc ? 8'(in_data >> {grant_q, 3'b000}) : tx_data_q;
  assign tx_valid_d = acc || (tx_valid_q && !tx_ready);
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    terr_d = 1'b0;
    if (state_q == ARB) begin
      if (|in_valid) begin
        state_d = LOCK;
        grant_d = sel;
        ptr_d = sel;
        cnt_d = '0;
      end
    end else if (acc) begin
      cnt_d = '0;
      state_d = l_sh[0] ? ARB : LOCK;
    end else if (!v_sh[0] && TIMEOUT_CYCLES != 0) begin
      // fire on the stall that would bring the counter to TIMEOUT_CYCLES-1
      if ({1'b0, cnt_q} + 17'd1 >= LIM) begin
        terr_d = 1'b1;
        state_d = ARB;
        cnt_d = '0;
      end else cnt_d = cnt_q + 16'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= ARB;
      grant_q <= '0;
      ptr_q <= GRANT_W'(N_REQ - 1);
      tx_data_q <= '0;
      tx_valid_q <= 1'b0;
      terr_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q <= ptr_d;
      tx_data_q <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      terr_q <= terr_d;
      cnt_q <= cnt_d;
    end
  end
  assign tx_data = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign grant_id = grant_q;
  assign busy = state_q == LOCK;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed and random stimulus checked every cycle against a behavioural model of the arbiter
module tb_uart_tx_arbiter;
  localparam int N = 4, GW = 2, TO = 16;
  logic clk = 0, resetn = 0, tx_ready = 0;
  logic [8*N-1:0] in_data = '0;
  logic [N-1:0] in_valid = '0, in_last = '0, in_ready;
  logic [7:0] tx_data;
  logic tx_valid, busy, timeout_err;
  logic [GW-1:0] grant_id;
  always #5 clk = ~clk;
  uart_tx_arbiter #(.N_REQ(N), .GRANT_W(GW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .resetn(resetn), .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
    .in_ready(in_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err));
  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  bit m_lock, m_txv, m_terr;
  int m_g, m_ptr, m_stall;
  logic [7:0] m_data;
  logic [8:0] pq[N][$];
  bit pres[N], acc_now[N];
  int acc_c[N];
  int gate = 100, trmode = 0, cyc_n = 0, terr_cnt = 0, terr_cyc = 0;
  int gq[$];
  logic [7:0] xq[$];
  bit prev_busy = 0;
  task automatic model_reset();
    m_lock = 0; m_txv = 0; m_terr = 0; m_g = 0; m_ptr = N - 1; m_stall = 0; m_data = 0;
  endtask
  task automatic model_next();
    bit acc, t, found;
    int nxt;
    for (int i = 0; i < N; i++) acc_now[i] = 0;
    if (!resetn) begin
      model_reset();
      return;
    end
    t = 0;
    acc = m_lock && (!m_txv || tx_ready) && in_valid[m_g];
    if (acc) begin
      m_data = in_data[8*m_g +: 8];
      m_txv = 1;
      acc_now[m_g] = 1;
    end else if (m_txv && tx_ready) m_txv = 0;
    if (!m_lock) begin
      found = 0;
      for (int k = 1; k <= N; k++) begin
        nxt = (m_ptr + k) % N;
        if (!found && in_valid[nxt]) begin
          found = 1;
          m_g = nxt;
        end
      end
      if (found) begin
        m_ptr = m_g; m_lock = 1; m_stall = 0;
      end
    end else if (acc) begin
      m_stall = 0;
      if (in_last[m_g]) m_lock = 0;
    end else if (!in_valid[m_g] && TO != 0) begin
      m_stall++;
      if (m_stall >= TO - 1) begin
        t = 1; m_lock = 0; m_stall = 0;
      end
    end
    m_terr = t;
  endtask
  task automatic cyc();
    logic [N-1:0] exp_rdy;
    tx_ready = trmode == 0 ? 1'b1 : trmode == 1 ? (cyc_n % 3 == 0) : trmode == 2 ? 1'($urandom_range(1)) : 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!pres[i] && pq[i].size() > 0 && $urandom_range(99) < gate) pres[i] = 1;
      in_valid[i] = pres[i];
      if (pres[i]) {in_last[i], in_data[8*i +: 8]} = pq[i][0];
      else {in_last[i], in_data[8*i +: 8]} = 9'($urandom);
    end
    @(negedge clk);
    exp_rdy = (m_lock && (!m_txv || tx_ready)) ? N'(1) << m_g : '0;
    chk("busy", busy, m_lock);
    if (m_lock) chk("grant_id", grant_id, m_g);
    chk("tx_valid", tx_valid, m_txv);
    chk("tx_data", tx_data, m_data);
    chk("in_ready", in_ready, exp_rdy);
    chk("timeout_err", timeout_err, m_terr);
    if (busy && !prev_busy) gq.push_back(grant_id);
    prev_busy = busy;
    if (tx_valid && tx_ready) xq.push_back(tx_data);
    if (timeout_err) begin
      terr_cnt++;
      terr_cyc = cyc_n;
    end
    model_next();
    for (int i = 0; i < N; i++)
      if (acc_now[i]) begin
        void'(pq[i].pop_front());
        pres[i] = 0;
        acc_c[i] = cyc_n;
      end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask
  function automatic bit pending();
    for (int i = 0; i < N; i++) if (pq[i].size() > 0 || pres[i]) return 1;
    return m_lock || m_txv;
  endfunction
  task automatic drain(input int maxc);
    int c = 0;
    while (pending() && c < maxc) begin
      cyc();
      c++;
    end
    chk("drain_bound", c < maxc, 1);
  endtask
  initial begin
    int t0, len;
    bit pushed;
    model_reset();
    for (int i = 0; i < N; i++) pres[i] = 0;
    cyc();
    cyc();
    chk("rst_busy", busy, 0);
    chk("rst_txv", tx_valid, 0);
    chk("rst_txd", tx_data, 0);
    chk("rst_rdy", in_ready, 0);
    resetn = 1;
    trmode = 1;
    pq[0] = '{9'h041, 9'h042, 9'h143};
    drain(200);
    chk("pkt_n", xq.size(), 3);
    for (int i = 0; i < 3 && i < xq.size(); i++) chk("pkt_byte", xq[i], 8'h41 + i);
    chk("pkt_gnt", gq.size() > 0 ? gq[0] : -1, 0);
    trmode = 0;
    gq.delete();
    pq[1] = '{9'h1A1};
    pq[2] = '{9'h1A2};
    drain(100);
    pq[1] = '{9'h1A3};
    drain(100);
    chk("rr_n", gq.size(), 3);
    if (gq.size() == 3) begin
      chk("rr_0", gq[0], 1);
      chk("rr_1", gq[1], 2);
      chk("rr_2", gq[2], 1);
    end
    gq.delete();
    pushed = 0;
    pq[0] = '{9'h0D0, 9'h0D1, 9'h0D2, 9'h1D3};
    for (int c = 0; c < 50 && !pushed; c++) begin
      cyc();
      if (pq[0].size() == 3) begin
        pq[3] = '{9'h1DE};
        pushed = 1;
      end
    end
    drain(100);
    chk("atom_n", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("atom_0", gq[0], 0);
      chk("atom_1", gq[1], 3);
    end
    trmode = 3;
    t0 = terr_cnt;
    pq[2] = '{9'h02A, 9'h02B, 9'h12C};
    for (int c = 0; c < 105; c++) cyc();
    chk("bp_terr", terr_cnt - t0, 0);
    chk("bp_data", tx_data, 8'h2A);
    chk("bp_txv", tx_valid, 1);
    chk("bp_rdy", in_ready, 0);
    trmode = 0;
    drain(100);
    gq.delete();
    t0 = terr_cnt;
    pq[0] = '{9'h0E0};
    pq[1] = '{9'h1E1};
    drain(200);
    chk("to_cnt", terr_cnt - t0, 1);
    chk("to_dist", terr_cyc - acc_c[0], 16);
    chk("to_n", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("to_g0", gq[0], 0);
      chk("to_g1", gq[1], 1);
    end
    pq[0] = '{9'h0F1, 9'h0F2, 9'h0F3, 9'h1F4};
    for (int c = 0; c < 50 && pq[0].size() != 3; c++) cyc();
    resetn = 0;
    cyc();
    resetn = 1;
    for (int i = 0; i < N; i++) begin
      pq[i].delete();
      pres[i] = 0;
    end
    chk("rm_txv", tx_valid, 0);
    chk("rm_busy", busy, 0);
    chk("rm_rdy", in_ready, 0);
    gq.delete();
    pq[1] = '{9'h1B1};
    pq[0] = '{9'h1B0};
    drain(100);
    chk("rm_prio", gq.size() > 0 ? gq[0] : -1, 0);
    trmode = 2;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) gate = $urandom_range(90, 30);
      for (int i = 0; i < N; i++)
        if (pq[i].size() == 0 && $urandom_range(3) == 0) begin
          len = $urandom_range(4, 1);
          for (int b = 0; b < len; b++) pq[i].push_back({1'(b == len - 1), 8'($urandom)});
        end
      cyc();
    end
    gate = 100;
    drain(2000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
